// File: rtl/pixel_seq_ctrl_if.sv
// Control/status bundle between the register block and the MixPix readout sequencer.
// The master side owns config and commands; the slave side drives the analog macro controls.
interface pixel_seq_ctrl_if #(
   parameter int N_PD  = 12,
   parameter int CNT_W = 8
);
   logic             start_i;
   logic             abort_i;
   logic             cont_i;
   logic [N_PD-1:0]  ch_en_i;
   logic [CNT_W-1:0] t_rst_i;
   logic [CNT_W-1:0] t_int_i;
   logic [CNT_W-1:0] t_sh_i;
   logic [CNT_W-1:0] t_cmp_i;
   logic [2:0]       route_i;
   logic             cmp_i;
   logic             sh_rst_o;
   logic             sw1_o;
   logic             sh_o;
   logic             sh_cmp_o;
   logic [N_PD-1:0]  pd_a_o;
   logic [N_PD-1:0]  pd_b_o;
   logic [4:0]       tg_o;
   logic [N_PD-1:0]  code_o;
   logic             code_vld_o;
   logic             busy_o;

   modport master (
      output start_i, abort_i, cont_i, ch_en_i, t_rst_i, t_int_i, t_sh_i, t_cmp_i,
             route_i, cmp_i,
      input  sh_rst_o, sw1_o, sh_o, sh_cmp_o, pd_a_o, pd_b_o, tg_o, code_o,
             code_vld_o, busy_o
   );

   modport slave (
      input  start_i, abort_i, cont_i, ch_en_i, t_rst_i, t_int_i, t_sh_i, t_cmp_i,
             route_i, cmp_i,
      output sh_rst_o, sw1_o, sh_o, sh_cmp_o, pd_a_o, pd_b_o, tg_o, code_o,
             code_vld_o, busy_o
   );
endinterface

// File: rtl/pixel_seq_ctrl.sv
// Readout sequencer for N_PD photodiode pairs: RST -> INT -> per-channel SH/CMP -> DONE.
// All outputs are registered and decoded from the next state so they align with the phase.
module pixel_seq_ctrl #(
   parameter int N_PD  = 12,
   parameter int CNT_W = 8
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   pixel_seq_ctrl_if.slave   bus
);
   localparam int KW = $clog2(N_PD);

   typedef enum logic [2:0] {S_IDLE, S_RST, S_INT, S_SH, S_CMP, S_DONE} state_t;

   state_t           state, nxt_state;
   logic [CNT_W-1:0] cnt, nxt_cnt;
   logic [KW-1:0]    k, nxt_k, nk, nxt_kb;
   logic             nk_vld;
   logic [N_PD-1:0]  en_q, shadow, nxt_shadow;
   logic [CNT_W-1:0] t_int_q, t_sh_q, t_cmp_q;
   logic             cmp_s1, cmp_s2;
   logic             latch, cap, in_pair;

   // A programmed length of zero still occupies one cycle.
   function automatic logic [CNT_W-1:0] ld(input logic [CNT_W-1:0] l);
      return (l == '0) ? '0 : l - 1'b1;
   endfunction

   function automatic logic [KW-1:0] first_en(input logic [N_PD-1:0] m);
      logic [KW-1:0] r;
      r = '0;
      for (int i = N_PD-1; i >= 0; i--)
         if (m[i]) r = KW'(i);
      return r;
   endfunction

   function automatic logic [N_PD-1:0] onehot(input logic [KW-1:0] i);
      return {{(N_PD-1){1'b0}}, 1'b1} << i;
   endfunction

   function automatic logic [4:0] route_tg(input logic [2:0] r);
      case (r)
         3'd1:    return 5'b00010;
         3'd2:    return 5'b00100;
         3'd3:    return 5'b01000;
         3'd4:    return 5'b10000;
         default: return 5'b00001;
      endcase
   endfunction

   // Next enabled channel strictly above the current one; disabled ones cost no cycles.
   always_comb begin
      nk     = '0;
      nk_vld = 1'b0;
      for (int i = N_PD-1; i >= 0; i--)
         if (en_q[i] && i > int'(k)) begin
            nk     = KW'(i);
            nk_vld = 1'b1;
         end
   end

   always_comb begin
      nxt_state = state;
      nxt_cnt   = cnt;
      nxt_k     = k;
      latch     = 1'b0;
      cap       = 1'b0;
      case (state)
         S_IDLE:
            if (bus.start_i && !bus.abort_i) begin
               latch     = 1'b1;
               nxt_state = S_RST;
               nxt_k     = first_en(bus.ch_en_i);
               nxt_cnt   = ld(bus.t_rst_i);
            end
         S_RST:
            if (cnt == '0) begin
               nxt_state = S_INT;
               nxt_cnt   = ld(t_int_q);
            end else nxt_cnt = cnt - 1'b1;
         S_INT:
            if (cnt == '0) begin
               if (en_q == '0) nxt_state = S_DONE;
               else begin
                  nxt_state = S_SH;
                  nxt_k     = first_en(en_q);
                  nxt_cnt   = ld(t_sh_q);
               end
            end else nxt_cnt = cnt - 1'b1;
         S_SH:
            if (cnt == '0) begin
               nxt_state = S_CMP;
               nxt_cnt   = ld(t_cmp_q);
            end else nxt_cnt = cnt - 1'b1;
         S_CMP:
            if (cnt == '0) begin
               cap = 1'b1;
               if (nk_vld) begin
                  nxt_state = S_SH;
                  nxt_k     = nk;
                  nxt_cnt   = ld(t_sh_q);
               end else nxt_state = S_DONE;
            end else nxt_cnt = cnt - 1'b1;
         S_DONE:
            if (bus.cont_i) begin
               latch     = 1'b1;
               nxt_state = S_RST;
               nxt_k     = first_en(bus.ch_en_i);
               nxt_cnt   = ld(bus.t_rst_i);
            end else nxt_state = S_IDLE;
         default: nxt_state = S_IDLE;
      endcase
      // Abort beats every transition, including a free-running restart.
      if (bus.abort_i && state != S_IDLE) begin
         nxt_state = S_IDLE;
         latch     = 1'b0;
         cap       = 1'b0;
      end
   end

   always_comb begin
      nxt_shadow = shadow;
      if (latch)    nxt_shadow = '0;
      else if (cap) nxt_shadow = shadow | ({{(N_PD-1){1'b0}}, cmp_s2} << k);
   end

   assign in_pair = (nxt_state == S_SH) || (nxt_state == S_CMP);
   assign nxt_kb  = (nxt_k == KW'(N_PD-1)) ? '0 : nxt_k + 1'b1;

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state          <= S_IDLE;
         cnt            <= '0;
         k              <= '0;
         en_q           <= '0;
         t_int_q        <= '0;
         t_sh_q         <= '0;
         t_cmp_q        <= '0;
         cmp_s1         <= 1'b0;
         cmp_s2         <= 1'b0;
         shadow         <= '0;
         bus.sh_rst_o   <= 1'b0;
         bus.sw1_o      <= 1'b0;
         bus.sh_o       <= 1'b0;
         bus.sh_cmp_o   <= 1'b0;
         bus.pd_a_o     <= '0;
         bus.pd_b_o     <= '0;
         bus.tg_o       <= 5'b00001;
         bus.code_o     <= '0;
         bus.code_vld_o <= 1'b0;
         bus.busy_o     <= 1'b0;
      end else begin
         cmp_s1 <= bus.cmp_i;
         cmp_s2 <= cmp_s1;
         state  <= nxt_state;
         cnt    <= nxt_cnt;
         k      <= nxt_k;
         shadow <= nxt_shadow;
         if (latch) begin
            en_q     <= bus.ch_en_i;
            t_int_q  <= bus.t_int_i;
            t_sh_q   <= bus.t_sh_i;
            t_cmp_q  <= bus.t_cmp_i;
            bus.tg_o <= route_tg(bus.route_i);
         end
         bus.sh_rst_o   <= (nxt_state == S_RST);
         bus.sw1_o      <= (nxt_state == S_INT);
         bus.sh_o       <= (nxt_state == S_SH);
         bus.sh_cmp_o   <= (nxt_state == S_CMP);
         bus.pd_a_o     <= in_pair ? onehot(nxt_k)  : '0;
         bus.pd_b_o     <= in_pair ? onehot(nxt_kb) : '0;
         bus.busy_o     <= (nxt_state != S_IDLE);
         bus.code_vld_o <= (nxt_state == S_DONE);
         if (nxt_state == S_DONE) bus.code_o <= nxt_shadow;
      end
   end
endmodule

// File: tb/tb_pixel_seq_ctrl.sv
// Bench for pixel_seq_ctrl: table of frames scored through a queue, plus hand sequences
// for busy-start, abort, start+abort, free-running and mid-frame reset.
`timescale 1ns/1ps
module tb_pixel_seq_ctrl;
   localparam int N_PD  = 12;
   localparam int CNT_W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pixel_seq_ctrl_if #(.N_PD(N_PD), .CNT_W(CNT_W)) bus ();
   pixel_seq_ctrl #(.N_PD(N_PD), .CNT_W(CNT_W)) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .bus      (bus)
   );

   typedef struct {
      logic [N_PD-1:0] en;
      logic [7:0]      trst, tint, tsh, tcmp;
      logic [2:0]      route;
      logic            call;
      logic [N_PD-1:0] mask;
      logic [N_PD-1:0] code;
      logic [4:0]      tg;
   } vec_t;

   typedef struct {
      logic [N_PD-1:0] code;
      logic [N_PD-1:0] vis;
      int              lat;
      int              t0;
   } exp_t;

   vec_t            vt [6];
   exp_t            sb [$];
   int              n_vec = 0;
   int              n_err = 0;
   int              cyc   = 0;
   logic            cmp_all = 1'b0;
   logic [N_PD-1:0] cmp_mask = '0;
   logic [N_PD-1:0] vis;

   // Comparator follows the selected channel for the whole SH+CMP window.
   assign bus.cmp_i = cmp_all | (|(bus.pd_a_o & cmp_mask));

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic int max1(input logic [7:0] x);
      return (x == 0) ? 1 : int'(x);
   endfunction

   function automatic int lat_of(input vec_t v);
      return 1 + max1(v.trst) + max1(v.tint) + $countones(v.en) * (max1(v.tsh) + max1(v.tcmp));
   endfunction

   always @(negedge clk) begin : mon
      exp_t e;
      if (rst || !bus.busy_o) vis <= '0;
      else if (bus.pd_a_o != '0) begin
         vis <= vis | bus.pd_a_o;
         chk("pd_b_pair", bus.pd_b_o, {bus.pd_a_o[N_PD-2:0], bus.pd_a_o[N_PD-1]});
      end
      if (!rst && bus.code_vld_o) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL vld_unexpected: got code_vld with code 0x%0h, expected none", bus.code_o);
         end else begin
            e = sb.pop_front();
            chk("code", bus.code_o, e.code);
            chk("latency", cyc - e.t0, e.lat);
            chk("visited", vis, e.vis);
            vis <= '0;
         end
      end
   end

   task automatic start_frame(input vec_t v, input bit push);
      exp_t x;
      bus.ch_en_i = v.en;
      bus.t_rst_i = v.trst;
      bus.t_int_i = v.tint;
      bus.t_sh_i  = v.tsh;
      bus.t_cmp_i = v.tcmp;
      bus.route_i = v.route;
      cmp_all     = v.call;
      cmp_mask    = v.mask;
      bus.start_i = 1'b1;
      if (push) begin
         x.code = v.code;
         x.vis  = v.en;
         x.lat  = lat_of(v);
         x.t0   = cyc;
         sb.push_back(x);
      end
      @(negedge clk);
      bus.start_i = 1'b0;
   endtask

   task automatic wait_drain(input string nm, input int max);
      int n = 0;
      while (sb.size() != 0 && n < max) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL %s: timeout with %0d results outstanding, expected 0", nm, sb.size());
         sb.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      vec_t va;
      exp_t x;
      int   base, n;
      logic busy_ok;

      bus.start_i = 1'b0; bus.abort_i = 1'b0; bus.cont_i = 1'b0;
      bus.ch_en_i = '0; bus.t_rst_i = '0; bus.t_int_i = '0;
      bus.t_sh_i = '0; bus.t_cmp_i = '0; bus.route_i = '0;

      //          en       trst  tint  tsh   tcmp  rt    call  mask     code     tg
      vt[0] = '{12'hFFF, 8'd2, 8'd3, 8'd1, 8'd2, 3'd0, 1'b1, 12'h000, 12'hFFF, 5'b00001};
      vt[1] = '{12'hFFF, 8'd2, 8'd3, 8'd1, 8'd2, 3'd2, 1'b0, 12'h821, 12'h821, 5'b00100};
      vt[2] = '{12'h005, 8'd1, 8'd0, 8'd0, 8'd0, 3'd4, 1'b1, 12'h000, 12'h005, 5'b10000};
      vt[3] = '{12'h0A0, 8'd0, 8'd5, 8'd2, 8'd1, 3'd7, 1'b0, 12'h020, 12'h020, 5'b00001};
      vt[4] = '{12'h801, 8'd2, 8'd3, 8'd1, 8'd2, 3'd3, 1'b0, 12'h800, 12'h800, 5'b01000};
      vt[5] = '{12'h000, 8'd3, 8'd4, 8'd1, 8'd1, 3'd1, 1'b1, 12'h000, 12'h000, 5'b00010};

      repeat (3) @(negedge clk);
      chk("rst_phases", {bus.sh_rst_o, bus.sw1_o, bus.sh_o, bus.sh_cmp_o}, 4'b0000);
      chk("rst_pd", {bus.pd_a_o, bus.pd_b_o}, '0);
      chk("rst_tg", bus.tg_o, 5'b00001);
      chk("rst_code", {bus.code_o, bus.code_vld_o, bus.busy_o}, '0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         start_frame(vt[i], 1'b1);
         chk($sformatf("tg_v%0d", i), bus.tg_o, vt[i].tg);
         chk($sformatf("busy_v%0d", i), bus.busy_o, 1'b1);
         wait_drain($sformatf("drain_v%0d", i), 200);
         chk($sformatf("idle_v%0d", i), bus.busy_o, 1'b0);
      end

      // start pulse (with a different mask) while busy must not disturb the frame
      start_frame(vt[0], 1'b1);
      repeat (4) @(negedge clk);
      bus.ch_en_i = 12'h000;
      bus.start_i = 1'b1;
      @(negedge clk);
      bus.start_i = 1'b0;
      bus.ch_en_i = 12'hFFF;
      wait_drain("busy_start", 200);

      // abort in CMP of channel 4: outputs drop, previous code (FFF) held
      va = vt[0]; va.call = 1'b0; va.mask = '0;
      start_frame(va, 1'b0);
      n = 0;
      while (!(bus.pd_a_o[4] && bus.sh_cmp_o) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("abort_reach_ch4", bus.pd_a_o[4] & bus.sh_cmp_o, 1'b1);
      bus.abort_i = 1'b1;
      @(negedge clk);
      bus.abort_i = 1'b0;
      chk("abort_busy", bus.busy_o, 1'b0);
      chk("abort_phases", {bus.sh_rst_o, bus.sw1_o, bus.sh_o, bus.sh_cmp_o}, 4'b0000);
      chk("abort_pd", {bus.pd_a_o, bus.pd_b_o}, '0);
      chk("abort_code", {bus.code_o, bus.code_vld_o}, {12'hFFF, 1'b0});
      repeat (5) @(negedge clk);

      // start together with abort in IDLE is ignored
      bus.start_i = 1'b1;
      bus.abort_i = 1'b1;
      @(negedge clk);
      bus.start_i = 1'b0;
      bus.abort_i = 1'b0;
      chk("start_abort_idle", bus.busy_o, 1'b0);

      // free-running with nothing enabled: RST, INT, DONE every 3 cycles
      va = '{12'h000, 8'd0, 8'd0, 8'd0, 8'd0, 3'd0, 1'b0, 12'h000, 12'h000, 5'b00001};
      bus.cont_i = 1'b1;
      base = cyc;
      start_frame(va, 1'b1);
      for (int i = 1; i < 4; i++) begin
         x.code = '0; x.vis = '0; x.lat = 3; x.t0 = base + 3 * i;
         sb.push_back(x);
      end
      busy_ok = 1'b1;
      while (cyc < base + 12) begin
         busy_ok &= bus.busy_o;
         @(negedge clk);
      end
      busy_ok &= bus.busy_o;
      bus.cont_i = 1'b0;
      chk("cont_busy_held", busy_ok, 1'b1);
      wait_drain("cont_drain", 50);
      chk("cont_stop_idle", bus.busy_o, 1'b0);

      // asynchronous reset during INT
      start_frame(vt[0], 1'b0);
      n = 0;
      while (!bus.sw1_o && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("rst_reach_int", bus.sw1_o, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("midrst_phases", {bus.sh_rst_o, bus.sw1_o, bus.sh_o, bus.sh_cmp_o}, 4'b0000);
      chk("midrst_tg", bus.tg_o, 5'b00001);
      chk("midrst_code", {bus.code_o, bus.code_vld_o, bus.busy_o}, '0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      start_frame(vt[1], 1'b1);
      wait_drain("post_reset", 200);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
